// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide unit for the execute stage.
// Takes one operation per req_valid/req_ready handshake, iterates radix-2
// (shift-add multiply, restoring divide) over XLEN cycles and returns a
// one-cycle res_valid pulse tagged with rd. Division by zero and signed
// overflow finish one cycle after accept without iterating.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            kills the operation in flight or the one being requested
//   req_valid/ready  issue handshake; ready only while idle
//   m_op             0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   op_a, op_b       rs1 / rs2 values
//   rd_in            destination register of the request
//   busy             high whenever an operation is in flight (stalls issue)
//   res_valid        one-cycle result strobe
//   res, rd_out      registered result and destination, held between strobes
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      m_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] res,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0] hi_q;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q;     // multiplier bits / dividend bits -> quotient
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic s);
    return s ? -v : v;
  endfunction

  // Applies the latched sign and selects the architectural result from the
  // final accumulator contents.
  function automatic logic [XLEN-1:0] final_res(input logic [2:0] op,
                                                input logic neg,
                                                input logic [XLEN-1:0] hi,
                                                input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] full;
    logic [XLEN-1:0]   r;
    full = {hi, lo};
    if (!op[2]) begin
      if (neg) full = -full;
      r = (op == 3'd0) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    end else if (op[1]) begin
      r = neg ? -hi : hi;
    end else begin
      r = neg ? -lo : lo;
    end
    return r;
  endfunction

  // Request decode
  logic            is_div, a_signed, b_signed, sa, sb, sign_in;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_val;

  always_comb begin
    is_div   = m_op[2];
    a_signed = (m_op == 3'd1) || (m_op == 3'd2) || (m_op == 3'd4) || (m_op == 3'd6);
    b_signed = (m_op == 3'd1) || (m_op == 3'd4) || (m_op == 3'd6);
    sa       = a_signed & op_a[XLEN-1];
    sb       = b_signed & op_b[XLEN-1];
    a_mag    = magnitude(op_a, sa);
    b_mag    = magnitude(op_b, sb);
    // REM takes the dividend's sign; every other op uses sign(a)^sign(b),
    // which is zero for unsigned operands since sa/sb are already masked.
    sign_in  = (m_op == 3'd6) ? sa : (sa ^ sb);
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !m_op[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (op_b == '1);
    fast     = div_zero || div_ovf;
    // Zero divisor: quotient all ones, remainder = dividend.
    // Overflow: quotient = dividend (most negative), remainder = 0.
    if (div_zero) fast_val = m_op[1] ? op_a : '1;
    else          fast_val = m_op[1] ? '0 : op_a;
  end

  // One radix-2 iteration
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (div_shift >= {1'b0, opnd_q}) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_shift[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Product shifts right through {carry, hi, lo} as multiplier bits retire.
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      res    <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            op_q   <= m_op;
            rd_q   <= rd_in;
            neg_q  <= sign_in;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            opnd_q <= is_div ? b_mag : a_mag;
            if (fast) begin
              res    <= fast_val;
              rd_out <= rd_in;
              state  <= DONE;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
              res    <= final_res(op_q, neg_q, step_hi, step_lo);
              rd_out <= rd_q;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // A flush arriving in the result cycle still swallows the strobe.
  assign res_valid = (state == DONE) && !flush;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, busy, res_valid;
  logic [2:0]  m_op;
  logic [31:0] op_a, op_b, res;
  logic [4:0]  rd_in, rd_out;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid),
    .req_ready(req_ready), .m_op(m_op), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .busy(busy), .res_valid(res_valid), .res(res),
    .rd_out(rd_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: remaining busy cycles (last one is the result cycle)
  int          busy_rem = 0;
  logic [31:0] exp_res = '0, pend_res = '0;
  logic [4:0]  exp_rd = '0, pend_rd = '0;
  int          dut_accepts = 0;
  logic        seen_valid;
  logic [31:0] seen_res;
  logic [4:0]  seen_rd;

  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * longint'(ub);
      3'd3: p = ua * ub;
      default: p = '0;
    endcase
    case (op)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb;
        return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    return op[2] && ((b == 0) ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare this cycle's outputs against the model, advance the model over
  // the coming edge, then move to just after that edge.
  task automatic tick();
    #1;
    check("busy", 32'(busy), 32'(busy_rem > 0));
    check("req_ready", 32'(req_ready), 32'(busy_rem == 0));
    check("res_valid", 32'(res_valid), 32'(busy_rem == 1 && !flush));
    check("res", res, exp_res);
    check("rd_out", 32'(rd_out), 32'(exp_rd));
    seen_valid = res_valid;
    seen_res   = res;
    seen_rd    = rd_out;
    if (!rst && req_valid && req_ready && !flush) dut_accepts++;
    if (rst) begin
      busy_rem = 0; exp_res = '0; exp_rd = '0;
    end else if (busy_rem > 0) begin
      if (flush) busy_rem = 0;
      else begin
        busy_rem--;
        if (busy_rem == 1) begin exp_res = pend_res; exp_rd = pend_rd; end
      end
    end else if (req_valid && !flush) begin
      pend_res = ref_result(m_op, op_a, op_b);
      pend_rd  = rd_in;
      if (is_fast(m_op, op_a, op_b)) begin
        busy_rem = 1; exp_res = pend_res; exp_rd = pend_rd;
      end else begin
        busy_rem = XLEN + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && busy_rem > 0; i++) tick();
  endtask

  // Directed operation: pins the model to a literal, then runs it through
  // the DUT and checks latency, result and rd.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit,
                        input int lat_exp);
    int lat;
    check({name, "_model"}, ref_result(op, a, b), lit);
    drain();
    m_op = op; op_a = a; op_b = b; rd_in = rd; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    seen_valid = 1'b0;
    while (!seen_valid && lat <= 40) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, lat_exp);
    check({name, "_res"}, seen_res, lit);
    check({name, "_rd"}, 32'(seen_rd), 32'(rd));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
    m_op = '0; op_a = '0; op_b = '0; rd_in = '0;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    tick();
    check("reset_res", res, 32'h0);
    check("reset_ready", 32'(req_ready), 32'h1);

    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33);
    run_op("mul_neg",   3'd0, 32'hFFFF_FFFD, 32'd7, 5'd5, 32'hFFFF_FFEB, 33);
    run_op("mulh_neg",  3'd1, 32'hFFFF_FFFD, 32'd7, 5'd6, 32'hFFFF_FFFF, 33);
    run_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 33);
    run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, 33);
    run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, 33);
    run_op("divu",      3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 33);
    run_op("remu",      3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 33);
    run_op("divu_zero", 3'd5, 32'd1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_op("rem_zero",  3'd6, 32'd1234, 32'd0, 5'd13, 32'd1234, 1);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);

    // Flush at count=10: killed, no strobe, res keeps the previous result
    m_op = 3'd5; op_a = 32'd500; op_b = 32'd3; rd_in = 5'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", 32'(busy), 32'h0);
    check("flush_res_kept", res, 32'h8000_0000);
    repeat (40) tick();

    // Request together with flush while idle is not taken
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("reqflush_ready", 32'(req_ready), 32'h1);
    tick();

    // Flush in the result cycle suppresses the strobe
    m_op = 3'd5; op_a = 32'd9; op_b = 32'd0; rd_in = 5'd21; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // Reset in the middle of an iteration
    m_op = 3'd0; op_a = 32'd12345; op_b = 32'd678; rd_in = 5'd22; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_res", res, 32'h0);
    check("midrst_rd", 32'(rd_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    tick();

    // Request held through an operation is taken again only after DONE
    dut_accepts = 0;
    m_op = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd23; req_valid = 1'b1;
    repeat (36) tick();
    req_valid = 1'b0;
    check("held_accepts", dut_accepts, 2);
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int mode;
      rst       = ($urandom_range(0, 399) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      req_valid = $urandom_range(0, 1);
      m_op      = 3'($urandom_range(0, 7));
      rd_in     = 5'($urandom_range(0, 31));
      mode      = $urandom_range(0, 5);
      op_a      = $urandom;
      op_b      = $urandom;
      if (mode == 1) op_b = '0;
      if (mode == 2) begin op_a = 32'h8000_0000; op_b = 32'hFFFF_FFFF; end
      if (mode == 3) begin op_a = 32'($urandom_range(0, 255)); op_b = 32'($urandom_range(1, 15)); end
      if (mode == 4) op_b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer and datapath for the RV32M multiply/divide operations in the execute stage.
- Replaces the single-cycle combinational mul_div path.
- Accepts one operation per valid/ready handshake from issue, iterates radix-2 (shift-add multiply, restoring shift-subtract divide), then returns a one-cycle result pulse tagged with rd.
- Drives a stall so issue holds while an operation is in flight; a pipeline flush kills it.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill in-flight or requested operation.
- req_valid  input  1  issue presents an operation.
- req_ready  output  1  block can accept; high only in IDLE.
- m_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- rd_in  input  5  destination register.
- busy  output  1  high when state != IDLE; stalls issue.
- res_valid  output  1  one-cycle pulse, result valid.
- res  output  XLEN  result; held until the next res_valid.
- rd_out  output  5  rd of the completed operation.

Behaviour:
- Reset: when rst is high at posedge, the next state is IDLE.
  - res_valid=0, res=0, rd_out=0, busy=0, req_ready=1.
  - Counter and internal accumulators are cleared.
- States: IDLE, CALC, DONE.
- Accept: occurs when req_valid && req_ready && !flush at a posedge.
  - Latch m_op and rd_in.
  - Latch magnitudes: |op_a| and |op_b| for signed operands. op_a is signed for MULH/MULHSU/DIV/REM; op_b is signed for MULH/DIV/REM. Otherwise raw values.
  - Latch result sign:
    - multiply: sign(a) XOR sign(b), over signed operands only.
    - DIV: sign(a) XOR sign(b).
    - REM: sign(a).
- Fast path: on accept, go directly to DONE (no CALC) in these cases:
  - divide/rem by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result op_a.
  - signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV result 0x80000000, REM result 0.
- Otherwise, accept goes IDLE->CALC with count=0. CALC performs one iteration per cycle, count increments, XLEN iterations total.
- Multiply: 2*XLEN-bit product accumulator.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - When the sign is negative, apply two's-complement negation to the full 2*XLEN product before selecting the half.
- Divide: restoring algorithm on magnitudes.
  - Quotient is negated if the DIV sign is set; remainder is negated if the REM sign is set.
- When count reaches XLEN-1 in CALC, the next state is DONE.
- DONE: res_valid=1 and rd_out valid for exactly one cycle; the next state is IDLE.
  - res and rd_out are registered outputs, stable during the res_valid cycle and held afterwards.
- Latency, counting from the accept edge:
  - normal: res_valid is high in the cycle after XLEN CALC cycles, i.e. 33 cycles for XLEN=32.
  - fast path: res_valid is high in the cycle right after accept, i.e. 1 cycle.
- Throughput: no back-to-back accept. req_ready is low in CALC and DONE, so the next accept is possible in the cycle after DONE.
- Flush:
  - in CALC or DONE: the next state is IDLE, and res_valid is not asserted for the killed operation (flush in DONE suppresses the pulse).
  - coinciding with req_valid in IDLE: the request is not accepted, and the state stays IDLE.
- rst has priority over flush; flush has priority over accept and over CALC progress.
- req_valid while busy: ignored, with no state change; issue must hold the request.

Test Plan:
- MULHU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> res_valid 33 cycles after accept, res=0xFFFFFFFE; busy high for 33 cycles.
- MUL op_a=0xFFFFFFFD (-3), op_b=7, rd_in=5 -> res=0xFFFFFFEB, rd_out=5; MULH on the same operands -> res=0xFFFFFFFF.
- DIV op_a=-7 (0xFFFFFFF9), op_b=2 -> res=0xFFFFFFFD; REM on the same operands -> res=0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path:
  - DIVU op_b=0 -> res=0xFFFFFFFF one cycle after accept.
  - REM op_a=0x80000000, op_b=0xFFFFFFFF -> res=0 one cycle after accept.
  - Neither case asserts busy for more than 1 cycle.
- Flush at CALC count=10 -> IDLE next cycle, no res_valid, res unchanged. req_valid+flush in IDLE -> not accepted; req_ready stays 1.
- rst asserted mid-CALC -> all outputs 0 and IDLE next cycle. req_valid held during busy -> accepted exactly once, in the cycle after DONE.
